// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity
// type encodings and the legal oversampling range.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_MIN = 8;
  localparam int PRESCALE_MAX = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and sample-point decision for uart_rx.
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority vote.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_s,
  input  logic                      cnt_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_val,
  output logic                      sample_done,
  output logic                      bit_end
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] half;

  assign half    = prescale >> 1;
  assign bit_end = (edge_cnt_q == (prescale - ONE));

  always_comb begin
    edge_cnt_d = '0;
    if (cnt_en && !bit_end) begin
      edge_cnt_d = edge_cnt_q + ONE;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a_q, vote_a_d;
  logic vote_b_q, vote_b_d;

  always_comb begin
    vote_a_d = vote_a_q;
    vote_b_d = vote_b_q;
    if (edge_cnt_q == (half - ONE)) vote_a_d = rx_s;
    if (edge_cnt_q == half)         vote_b_d = rx_s;
  end

  // Third sample is the live line, so the decision lands one count late.
  assign sample_done = (edge_cnt_q == (half + ONE));
  assign bit_val     = (vote_a_q & vote_b_q) | (vote_a_q & rx_s) | (vote_b_q & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
    end else begin
      vote_a_q <= vote_a_d;
      vote_b_q <= vote_b_d;
    end
  end
`else
  assign sample_done = (edge_cnt_q == half);
  assign bit_val     = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, frames start/data/parity/stop bits and
// strobes the received word. Build option: UART_RX_MAJORITY_VOTE_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Parity_Error,
  output logic                      Stop_Error
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  rx_state_e                 state_q, state_d;
  logic                      rx_meta_q, rx_s_q;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_err_q, par_err_d;
  logic                      stop_err_q, stop_err_d;
  logic                      data_valid_q, data_valid_d;
  logic                      parity_error_q, parity_error_d;
  logic                      stop_error_q, stop_error_d;

  logic                      cnt_en;
  logic                      bit_val, sample_done, bit_end;
  logic [PRESCALE_WIDTH-1:0] prescale_cur;

  // While idle the live Prescale drives the counter; it is frozen once a frame starts.
  assign prescale_cur = (state_q == IDLE) ? Prescale : prescale_q;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .rx_s       (rx_s_q),
    .cnt_en     (cnt_en),
    .prescale   (prescale_cur),
    .bit_val    (bit_val),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    cnt_en         = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_en = !rx_s_q;
        if (!rx_s_q) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      START: begin
        if (sample_done && bit_val) begin
          state_d = IDLE;
          cnt_en  = 1'b0;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_done) shift_d[bit_cnt_q] = bit_val;
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (sample_done) par_err_d = (bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (sample_done) stop_err_d = !bit_val;
        if (bit_end) begin
          state_d        = IDLE;
          data_valid_d   = !par_err_q && !stop_err_q;
          parity_error_d = par_err_q;
          stop_error_d   = stop_err_q;
          if (!par_err_q && !stop_err_q) p_data_d = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= PAR_EVEN;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_meta_q      <= RX_IN;
      rx_s_q         <= rx_meta_q;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign Data_Valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results, a
// negedge monitor pops and compares them whenever a strobe appears.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, parity_error, stop_error;

  typedef struct {
    logic [7:0] pdata;
    bit         valid;
    bit         perr;
    bit         serr;
    int         start;
    int         latency;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_count = 0;
  int   last_strobe_cyc = 0;
  int   prev_strobe_cyc = 0;
  bit   prev_strobe = 1'b0;

  uart_rx dut (
    .CLK         (clk_i),
    .RST         (rst),
    .RX_IN       (rx_in),
    .Prescale    (prescale),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .P_DATA      (p_data),
    .Data_Valid  (data_valid),
    .Parity_Error(parity_error),
    .Stop_Error  (stop_error)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every strobe cycle consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (!rst && (data_valid || parity_error || stop_error)) begin
      exp_t e;
      strobe_count++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      checkOutput("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("Data_Valid", {31'd0, data_valid}, {31'd0, e.valid});
        checkOutput("Parity_Error", {31'd0, parity_error}, {31'd0, e.perr});
        checkOutput("Stop_Error", {31'd0, stop_error}, {31'd0, e.serr});
        checkOutput("P_DATA", {24'd0, p_data}, {24'd0, e.pdata});
        checkOutput("latency", cyc - e.start, e.latency);
      end
    end
    prev_strobe = !rst && (data_valid || parity_error || stop_error);
  end

  task automatic driveBit(input logic v, input int ps, input bit pulse);
    rx_in = v;
    if (pulse) begin
      repeat (ps / 2) @(posedge clk_i);
      #1 rx_in = ~v;
      @(posedge clk_i);
      #1 rx_in = v;
      repeat (ps / 2 - 1) @(posedge clk_i);
    end else begin
      repeat (ps) @(posedge clk_i);
    end
    #1;
  endtask

  // Sends one frame starting at posedge+1 and queues its hand-computed result.
  task automatic applyStimulus(input logic [7:0] data, input int ps, input bit pen, input bit ptyp,
                               input bit par_bit, input bit stop_bit, input bit exp_valid,
                               input bit exp_perr, input bit exp_serr, input logic [7:0] exp_pdata,
                               input int latency, input int pulse_bit);
    exp_t e;
    prescale = ps[5:0];
    par_en   = pen;
    par_typ  = ptyp;
    e.pdata = exp_pdata;
    e.valid = exp_valid;
    e.perr  = exp_perr;
    e.serr  = exp_serr;
    e.start = cyc;
    e.latency = latency;
    exp_q.push_back(e);
    driveBit(1'b0, ps, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i], ps, (i == pulse_bit));
    if (pen) driveBit(par_bit, ps, 1'b0);
    driveBit(stop_bit, ps, 1'b0);
    rx_in = 1'b1;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk_i);
      n++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_P_DATA", {24'd0, p_data}, 32'd0);
    checkOutput("reset_Data_Valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_Parity_Error", {31'd0, parity_error}, 32'd0);
    checkOutput("reset_Stop_Error", {31'd0, stop_error}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;

    // 0xA5 even parity: good frame, then bad parity bit.
    applyStimulus(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 90, -1);
    repeat (5) @(posedge clk_i);
    #1;
    applyStimulus(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 90, -1);
    repeat (5) @(posedge clk_i);
    #1;
    // 0x3C, no parity, broken stop bit.
    applyStimulus(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 162, -1);
    waitDrain(200);

    // 3-cycle glitch must be rejected silently.
    base = strobe_count;
    prescale = 6'd8;
    rx_in = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rx_in = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    checkOutput("glitch_no_strobe", strobe_count - base, 32'd0);
    applyStimulus(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 90, -1);
    waitDrain(200);

    // Back-to-back odd-parity frames, no idle gap.
    applyStimulus(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 354, -1);
    applyStimulus(8'hFE, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 354, -1);
    waitDrain(500);
    checkOutput("back_to_back_spacing", last_strobe_cyc - prev_strobe_cyc, 32'd352);

    // Reset in the middle of data bit 3 of an all-zero frame.
    base = strobe_count;
    prescale = 6'd8;
    par_en = 1'b0;
    rx_in = 1'b0;
    repeat (8 + 3 * 8 + 4) @(posedge clk_i);
    #1 rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("midframe_reset_P_DATA", {24'd0, p_data}, 32'd0);
    checkOutput("midframe_reset_Data_Valid", {31'd0, data_valid}, 32'd0);
    rst = 1'b0;
    repeat (120) @(posedge clk_i);
    #1;
    checkOutput("aborted_frame_no_strobe", strobe_count - base, 32'd0);
    applyStimulus(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 82, -1);
    waitDrain(200);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // A one-cycle low pulse at the centre of data bit 2 is outvoted.
    applyStimulus(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 82, 2);
    waitDrain(200);
    checkOutput("total_strobes", strobe_count, 32'd8);
`else
    checkOutput("total_strobes", strobe_count, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
